// File: rtl/fp32_pkg.sv
// Shared float32 constants, field layout and the power-unit state encoding.
package fp32_pkg;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam int          BIAS    = 127;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MUL_ACC,
        S_MUL_SQR,
        S_FIN
    } canmu_state_t;

endpackage

// File: rtl/fp32_mul.sv
// Float32 multiplier, RNE rounding, subnormals flushed to signed zero.
// Latency: combinational.
// Backpressure: none, pure function of a and b.
module fp32_mul
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p,
    output logic        ovf
);

    fp32_t fa, fb;
    assign fa = a;
    assign fb = b;

    logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]       prod;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic              g, st, rnd;
    logic signed [9:0] ex;

    always_comb begin
        sgn    = fa.sign ^ fb.sign;
        a_nan  = (&fa.exp) & (|fa.frac);
        b_nan  = (&fb.exp) & (|fb.frac);
        a_inf  = (&fa.exp) & ~(|fa.frac);
        b_inf  = (&fb.exp) & ~(|fb.frac);
        a_zero = (fa.exp == '0);
        b_zero = (fb.exp == '0);
        prod   = {24'd0, 1'b1, fa.frac} * {24'd0, 1'b1, fb.frac};
        ex     = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'sd127;
        m      = prod[46:23];
        g      = prod[22];
        st     = |prod[21:0];
        if (prod[47]) begin
            m  = prod[47:24];
            g  = prod[23];
            st = |prod[22:0];
            ex = ex + 10'sd1;
        end
        rnd = g & (st | m[0]);
        mr  = {1'b0, m} + {24'd0, rnd};
        // Rounding carry out of the mantissa renormalises to 1.0 x 2^(ex+1)
        if (mr[24]) begin
            m  = mr[24:1];
            ex = ex + 10'sd1;
        end else begin
            m  = mr[23:0];
        end

        ovf = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = FP_QNAN;
        end else if (a_inf || b_inf) begin
            p = {sgn, FP_PINF[30:0]};
        end else if (a_zero || b_zero) begin
            p = {sgn, 31'd0};
        end else if (ex >= 10'sd255) begin
            p   = {sgn, FP_PINF[30:0]};
            ovf = 1'b1;
        end else if (ex <= 10'sd0) begin
            p = {sgn, 31'd0};
        end else begin
            p = {sgn, ex[7:0], m[22:0]};
        end
    end

endmodule

// File: rtl/canmu_n.sv
// Iterative float32 power y^n, square-and-multiply over one shared multiplier.
// Latency: 2 + popcount(e) + bitlen(e) - 1 cycles from accepted start to done; specials take 2.
// Backpressure: start is only accepted in IDLE; starts while busy are dropped.
module canmu_n
    import fp32_pkg::*;
#(
    parameter int N_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] y,
    input  logic [31:0] n,
    output logic        busy,
    output logic        done,
    output logic [31:0] ketqua,
    output logic        invalid,
    output logic        overflow
);

    localparam logic [8:0] BIG_EXP = 9'(BIAS + N_BITS);

    canmu_state_t        state;
    logic [31:0]         n_q, base, acc;
    logic [N_BITS-1:0]   e;
    logic [31:0]         mul_a, mul_p;
    logic                mul_ovf;

    assign mul_a = (state == S_MUL_ACC) ? acc : base;

    fp32_mul u_mul (
        .a   (mul_a),
        .b   (base),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    // Truncating float-to-unsigned conversion of the captured exponent
    logic [EXP_W-1:0]    n_exp;
    logic [7:0]          n_shift;
    logic [N_BITS+23:0]  n_wide;
    logic [N_BITS-1:0]   n_int;
    logic                n_bad, y_nan;

    always_comb begin
        n_exp   = n_q[30:23];
        n_shift = n_exp - 8'(BIAS);
        n_wide  = {{N_BITS{1'b0}}, 1'b1, n_q[22:0]} << n_shift;
        n_int   = (n_exp < 8'(BIAS)) ? '0 : n_wide[N_BITS+22:23];
        n_bad   = (&n_exp) || ({1'b0, n_exp} >= BIG_EXP) || (n_q[31] && (n_int != '0));
        y_nan   = (&base[30:23]) && (|base[22:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ketqua   <= '0;
            invalid  <= 1'b0;
            overflow <= 1'b0;
            n_q      <= '0;
            base     <= '0;
            acc      <= '0;
            e        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base     <= y;
                        n_q      <= n;
                        busy     <= 1'b1;
                        invalid  <= 1'b0;
                        overflow <= 1'b0;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    acc <= FP_ONE;
                    e   <= n_int;
                    if (n_bad) begin
                        acc     <= FP_QNAN;
                        invalid <= 1'b1;
                        state   <= S_FIN;
                    end else if (n_int == '0) begin
                        state   <= S_FIN;
                    end else if (y_nan) begin
                        acc     <= FP_QNAN;
                        invalid <= 1'b1;
                        state   <= S_FIN;
                    end else if (n_int[0]) begin
                        state   <= S_MUL_ACC;
                    end else begin
                        state   <= S_MUL_SQR;
                    end
                end
                S_MUL_ACC: begin
                    acc      <= mul_p;
                    overflow <= overflow | mul_ovf;
                    state    <= (|e[N_BITS-1:1]) ? S_MUL_SQR : S_FIN;
                end
                S_MUL_SQR: begin
                    base     <= mul_p;
                    overflow <= overflow | mul_ovf;
                    e        <= e >> 1;
                    // e > 1 here, so a clear next bit always means another square
                    state    <= e[1] ? S_MUL_ACC : S_MUL_SQR;
                end
                S_FIN: begin
                    ketqua <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_canmu_n.sv
// Directed-vector bench for canmu_n with hand-computed float32 results.
module tb_canmu_n;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] y, n;
    logic        busy, done, invalid, overflow;
    logic [31:0] ketqua;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int t0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    canmu_n #(.N_BITS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y        (y),
        .n        (n),
        .busy     (busy),
        .done     (done),
        .ketqua   (ketqua),
        .invalid  (invalid),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] yv, input logic [31:0] nv);
        @(negedge clk);
        y = yv;
        n = nv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc_cnt;
    endtask

    task automatic wait_done(output int lat);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 200);
        lat = done ? (cyc_cnt - t0) : -1;
    endtask

    task automatic do_op(input string tag, input logic [31:0] yv, input logic [31:0] nv,
                         input logic [31:0] exp_k, input int exp_lat,
                         input logic exp_inv, input logic exp_ovf);
        int lat;
        launch(yv, nv);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, ketqua, exp_k);
        check({tag, "_inv"}, 32'(invalid), 32'(exp_inv));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1;
        start = 1'b0;
        y = '0;
        n = '0;
        repeat (3) @(negedge clk);
        check("rst_state", {28'd0, busy, done, invalid, overflow}, 32'd0);
        check("rst_res", ketqua, 32'h0000_0000);
        rst = 1'b0;

        do_op("pow2_10",  32'h4000_0000, 32'h4120_0000, 32'h4480_0000, 7, 1'b0, 1'b0);
        do_op("p15_3",    32'h3FC0_0000, 32'h4040_0000, 32'h4058_0000, 5, 1'b0, 1'b0);
        do_op("neg2_3",   32'hC000_0000, 32'h4040_0000, 32'hC100_0000, 5, 1'b0, 1'b0);
        do_op("neg2_2",   32'hC000_0000, 32'h4000_0000, 32'h4080_0000, 4, 1'b0, 1'b0);
        do_op("n_zero",   32'h3E58_0000, 32'h0000_0000, 32'h3F80_0000, 2, 1'b0, 1'b0);
        do_op("n_frac",   32'h4040_0000, 32'h402C_CCCD, 32'h4110_0000, 4, 1'b0, 1'b0);
        do_op("n_negfr",  32'h4040_0000, 32'hBF00_0000, 32'h3F80_0000, 2, 1'b0, 1'b0);
        do_op("n_neg",    32'h4000_0000, 32'hC000_0000, 32'h7FC0_0000, 2, 1'b1, 1'b0);
        do_op("n_nan",    32'h4000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 2, 1'b1, 1'b0);
        do_op("n_inf",    32'h4000_0000, 32'h7F80_0000, 32'h7FC0_0000, 2, 1'b1, 1'b0);
        do_op("n_2p16",   32'h3F80_0000, 32'h4780_0000, 32'h7FC0_0000, 2, 1'b1, 1'b0);
        do_op("n_max",    32'h3F80_0000, 32'h477F_FF00, 32'h3F80_0000, 33, 1'b0, 1'b0);
        do_op("ynan_n0",  32'h7FC0_0000, 32'h0000_0000, 32'h3F80_0000, 2, 1'b0, 1'b0);
        do_op("ynan_n3",  32'h7FC0_0000, 32'h4040_0000, 32'h7FC0_0000, 2, 1'b1, 1'b0);
        do_op("ovf",      32'h7E80_0000, 32'h4000_0000, 32'h7F80_0000, 4, 1'b0, 1'b1);
        do_op("rne_sq",   32'h3F80_0001, 32'h4000_0000, 32'h3F80_0002, 4, 1'b0, 1'b0);

        // A second start while busy must be dropped
        launch(32'h4000_0000, 32'h4120_0000);
        start = 1'b1;
        y = 32'h4040_0000;
        n = 32'h40A0_0000;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ign_lat", 32'(lat), 32'd7);
        check("ign_res", ketqua, 32'h4480_0000);

        // Reset mid-operation aborts without a done
        @(negedge clk);
        launch(32'h4040_0000, 32'h4120_0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res", ketqua, 32'h0000_0000);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_nodone", 32'(seen), 32'd0);

        do_op("recover",  32'h4000_0000, 32'h4120_0000, 32'h4480_0000, 7, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/canmu_n.md
Name: canmu_n

Overview:
- Iterative IEEE-754 single-precision power unit: computes ketqua = y^n for a float32 base y and a float32 exponent n that carries an integer value.
- It is the inverse-direction companion of the team's combinational nth-root block: a root result raised by this block should recover the original y within rounding.
- It uses a square-and-multiply loop over one shared float32 multiplier, with a start/done handshake.

Parameters:
- N_BITS, 16, width of the unsigned integer exponent extracted from n; valid integer n range is 0..2^N_BITS-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when busy=0
- y  input  32  float32 base; captured on an accepted start
- n  input  32  float32 exponent; captured on an accepted start; fraction truncated toward zero
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when ketqua and the flags are valid
- ketqua  output  32  float32 result; held until the next accepted start
- invalid  output  1  n is negative, NaN, inf, or ≥2^N_BITS, or y is NaN; valid with done
- overflow  output  1  result saturated to ±inf from finite operands; valid with done

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, ketqua=0x00000000, invalid=0, overflow=0.
  - Reset asserted mid-operation aborts the operation on that edge; no done is produced.
- States: IDLE, PREP, MUL_ACC, MUL_SQR, FIN.
- IDLE:
  - start=1 captures y and n, sets busy=1, clears invalid/overflow, and moves to PREP.
  - start while busy is ignored and not queued.
- PREP:
  - e = trunc(|n|) as an N_BITS unsigned integer; acc=0x3F800000; base=y.
  - Special cases go straight to FIN, in priority order:
    - n NaN/inf, n<0 with e≠0, or e≥2^N_BITS: ketqua=0x7FC00000, invalid=1.
    - e=0 (this includes y=0, y=inf, y=NaN): ketqua=0x3F800000.
    - y NaN: ketqua=0x7FC00000, invalid=1.
  - Otherwise go to MUL_ACC.
- Loop: one multiply per cycle, LSB-first over e.
  - MUL_ACC:
    - If e[0]=1, acc ← acc×base; otherwise the state is skipped (zero cycles).
    - Then if e>1, go to MUL_SQR; else go to FIN.
  - MUL_SQR: base ← base×base; e ← e>>1; next state is MUL_ACC.
- FIN: ketqua=acc (or the special-case value), done=1 for exactly one cycle, busy=0, next state IDLE.
- Latency (accepted start edge to done high):
  - Normal operands: 2 + popcount(e) + (bitlen(e)−1) cycles.
  - Special cases: 2 cycles.
- Multiplier rules:
  - Rounding is round-to-nearest-even.
  - Subnormal inputs and outputs flush to signed zero.
  - Exponent overflow gives ±inf and sets sticky overflow. Inf input gives inf with no overflow.
  - Sign = XOR of the operand signs.
  - Negative y with odd e gives a negative result; with even e, a positive result.
- overflow is sticky across the loop and clears only on a new accepted start or reset.

Decomposition:
- Shared package fp32_pkg holds:
  - Constants FP_ONE=0x3F800000, FP_QNAN=0x7FC00000, FP_PINF=0x7F800000, BIAS=127.
  - Field widths (sign 1, exponent 8, fraction 23).
  - The state enum for canmu_n.
- One sub-module: fp32_mul. It is a combinational float32 multiplier with inputs a, b and outputs p, ovf, following the multiplier rules above, and is instantiated once.
- The float-to-integer conversion of n stays inline in PREP.

Test Plan:
- y=0x40000000 (2.0), n=0x41200000 (10.0) → ketqua=0x44800000 (1024.0), done exactly 7 cycles after start, invalid=0, overflow=0.
- y=0x3FC00000 (1.5), n=0x40400000 (3.0) → 0x40580000 (3.375), latency 5. Then y=0xC0000000 (−2.0), n=0x40400000 → 0xC1000000 (−8.0).
- y=0x3E580000, n=0x00000000 → 0x3F800000, latency 2. Then y=0x40400000 (3.0), n=0x402CCCCD (2.7) → 0x41100000 (9.0).
- y=0x40000000, n=0xC0000000 (−2.0) → 0x7FC00000, invalid=1, latency 2. Then n=0x7FC00000 → the same result.
- y=0x7E800000 (2^126), n=0x40000000 (2.0) → 0x7F800000, overflow=1, invalid=0.
- Start y=2.0, n=10.0; pulse start again with other operands at cycle 2 → ignored, result still 0x44800000. Then a new start with rst=1 at cycle 3 → busy=0, no done, ketqua=0 next cycle.
